// File: rtl/fft_r22sdf_ctrl_if.sv
// Handshake and pipeline-control bundle between the R22SDF sequencer and its datapath.
interface fft_r22sdf_ctrl_if #(
    parameter int unsigned N = 1024
);
    localparam int unsigned NLOG2  = $clog2(N);
    localparam int unsigned STAGES = NLOG2 / 2;
    localparam int unsigned TW_W   = (STAGES - 1) * NLOG2;

    logic              valid_i;
    logic              ready_o;
    logic [NLOG2-1:0]  in_idx_o;
    logic [STAGES-1:0] bfi_sel_o;
    logic [STAGES-1:0] bfii_sel_o;
    logic [STAGES-1:0] bfii_negj_o;
    logic [TW_W-1:0]   tw_exp_o;
    logic              valid_o;
    logic [NLOG2-1:0]  idx_o;
    logic              err_o;

    modport master (
        output valid_i,
        input  ready_o, in_idx_o, bfi_sel_o, bfii_sel_o, bfii_negj_o,
        input  tw_exp_o, valid_o, idx_o, err_o
    );

    modport slave (
        input  valid_i,
        output ready_o, in_idx_o, bfi_sel_o, bfii_sel_o, bfii_negj_o,
        output tw_exp_o, valid_o, idx_o, err_o
    );
endinterface

// File: rtl/fft_r22sdf_ctrl.sv
// Frame sequencer for an N-point R22SDF FFT: input handshake, per-stage butterfly
// and twiddle controls, and bit-reversed output tagging through the pipeline latency.
module fft_r22sdf_ctrl #(
    parameter int unsigned N      = 1024,
    parameter int unsigned TW_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_n,
    fft_r22sdf_ctrl_if.slave bus
);
    localparam int unsigned NLOG2  = $clog2(N);
    localparam int unsigned STAGES = NLOG2 / 2;
    localparam int unsigned TW_W   = (STAGES - 1) * NLOG2;
    localparam int unsigned LAT    = N - 1 + (STAGES - 1) * TW_LAT;
    localparam int unsigned LAT_Q  = LAT / N;
    localparam int unsigned LAT_R  = LAT % N;
    localparam int unsigned DEPTH  = LAT_Q + 1;
    localparam logic [NLOG2-1:0] CTR_LAST = NLOG2'(N - 1);

    logic [NLOG2-1:0]  ctr;
    logic              active;
    logic [DEPTH-1:0]  tags;

    logic              ready_c;
    logic              frame_done_c;
    logic              valid_c;
    logic [NLOG2-1:0]  out_cnt_c;
    logic [NLOG2-1:0]  idx_c;
    logic [STAGES-1:0] bfi_sel_c;
    logic [STAGES-1:0] bfii_sel_c;
    logic [STAGES-1:0] negj_c;
    logic [TW_W-1:0]   tw_c;

    assign ready_c      = rst_n & ((ctr == '0) | active);
    assign frame_done_c = active & bus.valid_i & (ctr == CTR_LAST);

    // tags[0] holds the most recently finished frame, older frames further up
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            ctr    <= '0;
            active <= 1'b0;
            tags   <= '0;
        end else begin
            ctr <= ctr + NLOG2'(1);
            if ((ctr == '0) && bus.valid_i) begin
                active <= 1'b1;
            end else if (frame_done_c || !bus.valid_i) begin
                active <= 1'b0;
            end
            if (ctr == CTR_LAST) begin
                tags[0] <= frame_done_c;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    tags[i] <= tags[i-1];
                end
            end
        end
    end

    // Pick the tag of the frame whose output sample is leaving the pipe this cycle
    if (LAT_R == 0) begin : g_aligned
        assign valid_c = tags[LAT_Q-1];
    end else if (LAT_Q == 0) begin : g_short
        assign valid_c = (ctr < NLOG2'(LAT_R)) ? tags[0] : frame_done_c;
    end else begin : g_split
        assign valid_c = (ctr < NLOG2'(LAT_R)) ? tags[LAT_Q] : tags[LAT_Q-1];
    end

    assign out_cnt_c = ctr - NLOG2'(LAT_R);

    always_comb begin
        idx_c = '0;
        for (int unsigned i = 0; i < NLOG2; i++) begin
            idx_c[i] = out_cnt_c[NLOG2-1-i];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned M   = NLOG2 - 2 * s;
        localparam int unsigned OFF = (s * TW_LAT) % N;
        logic [M-1:0] cs;

        assign cs            = M'(ctr - NLOG2'(OFF));
        assign bfi_sel_c[s]  = cs[M-1];
        assign bfii_sel_c[s] = cs[M-2];
        assign negj_c[s]     = cs[M-1] & ~cs[M-2];

        // e = r * (t1 + 2*t2), scaled by 4^s; the product already fits in M bits
        if (s < STAGES - 1) begin : g_tw
            logic [NLOG2-1:0] prod;
            assign prod = NLOG2'(cs[M-3:0]) * NLOG2'({cs[M-2], cs[M-1]});
            assign tw_c[s*NLOG2 +: NLOG2] = prod << (2 * s);
        end
    end

    assign bus.ready_o     = ready_c;
    assign bus.err_o       = rst_n & active & ~bus.valid_i;
    assign bus.valid_o     = rst_n & valid_c;
    assign bus.in_idx_o    = rst_n ? ctr : '0;
    assign bus.idx_o       = rst_n ? idx_c : '0;
    assign bus.bfi_sel_o   = rst_n ? bfi_sel_c : '0;
    assign bus.bfii_sel_o  = rst_n ? bfii_sel_c : '0;
    assign bus.bfii_negj_o = rst_n ? negj_c : '0;
    assign bus.tw_exp_o    = rst_n ? tw_c : '0;
endmodule

// File: doc/fft_r22sdf_ctrl.md
# fft_r22sdf_ctrl

Sequencer for an N-point radix-2² single-path delay-feedback (R22SDF) FFT pipeline. It owns the frame counter and accepts input samples through a valid/ready handshake. It drives every stage's BFI/BFII select and -j rotation controls, plus the twiddle ROM exponent for each inter-stage multiplier. It tracks frames through the N-1+pipeline latency and flags bit-reversed output samples with `valid_o`/`idx_o`.

## Interface
- `N`, 1024: FFT length; power of 4, ≥16.
- `NLOG2`, $clog2(N): index width (derived).
- `STAGES`, NLOG2/2: number of BFI+BFII stage pairs (derived).
- `TW_LAT`, 1: register latency of each inter-stage twiddle multiplier; 0 ≤ TW_LAT < N.
- `clk_i`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `valid_i`  in  1  upstream sample valid.
- `ready_o`  out  1  controller accepts a sample this cycle.
- `in_idx_o`  out  NLOG2  natural-order index of the sample being accepted.
- `bfi_sel_o`  out  STAGES  bit s: `sel_i` of stage s BFI.
- `bfii_sel_o`  out  STAGES  bit s: `sel_i` of stage s BFII.
- `bfii_negj_o`  out  STAGES  bit s: apply -j to the stage s BFII input.
- `tw_exp_o`  out  (STAGES-1)*NLOG2  slice s: twiddle exponent e for W_N^e after stage s.
- `valid_o`  out  1  last-stage output is a valid frame sample.
- `idx_o`  out  NLOG2  frequency bin of the current output (bit-reversed count).
- `err_o`  out  1  one-cycle pulse: frame aborted by a `valid_i` gap.

## Operation
- Global counter `ctr` (NLOG2 bits) is free-running modulo N after reset. SDF shift registers clock continuously, so all control derives from `ctr`.
- Handshake: `ready_o` = `rst_n` & (`ctr`==0 | `active`). A transfer occurs when `valid_i & ready_o`.
- Frame start:
  - A transfer at `ctr`==0 sets `active`.
  - `active` clears after the transfer at `ctr`==N-1.
  - Back-to-back frames are allowed, so `ready_o` stays high across the boundary.
- Abort: `active` & !`valid_i` at any `ctr` means:
  - `err_o` pulses for that cycle.
  - `active` clears, so `ready_o` drops until the next `ctr`==0.
  - The frame's valid tag is discarded; none of its samples ever raise `valid_o`.
- Idle (no frame, `ctr`≠0): `ready_o`=0. Pipeline controls keep running so in-flight frames drain correctly.
- `in_idx_o` = `ctr`.
- Stage-local count: c_s = (`ctr` − s·TW_LAT) mod N.
  - Let m = NLOG2 − 2s, t1 = c_s[m-1], t2 = c_s[m-2], r = c_s[m-3:0].
  - `bfi_sel_o`[s] = t1.
  - `bfii_sel_o`[s] = t2.
  - `bfii_negj_o`[s] = t1 & !t2.
- Twiddle after stage s (s < STAGES-1), using c taken at that multiplier's input, i.e. c_s:
  - e = (r·(t1 + 2·t2)) << 2s, truncated to NLOG2 bits.
  - The product never exceeds 3N/4−3 before shift scaling. The shifted result is taken mod N.
- Latency L = N−1 + (STAGES−1)·TW_LAT. Output sample k of a frame appears L+k cycles after that frame's input sample 0.
- Frame tags:
  - A depth of floor(L/N)+1 one-bit tags, advanced at frame boundaries, tracks accepted frames.
  - `valid_o` is high for exactly N consecutive cycles per completed frame.
- `idx_o` = bit-reverse(output count). Output count is (`ctr` − L) mod N.

## Timing
- Reset: `ctr`=0, `active`=0, tags cleared. All outputs 0, including `ready_o`.
- First cycle after reset release: `ready_o`=1 (`ctr`=0).
- `ctr`, `active` and tags are registered.
  - `ready_o`, `err_o` and `valid_o` are combinational from those registers plus `valid_i` only.
  - Sel/negj/exp outputs are decoded from registered counters, with no `valid_i` path.
- Abort in the same cycle a frame's first output would appear (possible when TW_LAT=0): `valid_o` stays 0.
- Reset mid-frame: all frames in flight are discarded. `valid_o` stays low until a new frame completes L cycles after its start.
- Continuous input gives `valid_o` continuously high after the first L cycles.

## Test plan
- N=16, TW_LAT=1 (L=16); reset, then `valid_i`=1 for 16 cycles from `ctr`=0 -> 16 transfers; `valid_o` high on cycles 16..31 after sample 0; `idx_o` sequence 0,8,4,12,2,…,15.
- Same config, impulse x[0]=1, all other samples 0, through a reference datapath -> all 16 bins = 1; constant input -> bin 0 = 16, other bins 0.
- `valid_i` raised at `ctr`=5 -> `ready_o`=0 until `ctr`=0; the frame starts then; `in_idx_o` counts 0..15.
- `valid_i` dropped at beat 7 -> `err_o`=1 for one cycle; `ready_o`=0 until the next `ctr`=0; no `valid_o` for that frame; the following good frame outputs normally.
- Stage 0 controls over one frame: `bfi_sel_o`[0] high for beats 8..15; `bfii_sel_o`[0] high for beats 4..7 and 12..15; `negj` high for beats 8..11; `tw_exp_o`[0] for beats 0..15 = 0,0,0,0,0,2,4,6,0,1,2,3,0,3,6,9, applied one cycle later.
- Three back-to-back frames, then reset asserted mid-second-output-frame -> all outputs 0 next cycle; after release, no `valid_o` until a fresh frame plus L.
